cpu_sequencer: RTL and testbench

Generates the CPU clock-enable strobe (cpuCe) and the 3-bit instruction phase counter (cycle, 0..7) consumed by the program counter and the rest of the CPU datapath. A run/halt/single-step state machine decides whether instructions execute. Every stop happens at an instruction boundary, after the cycle-7 commit, so the program counter is never left mid-instruction. Sits between the board buttons / decoder halt flag and all cpuCe/cycle consumers.

---
 rtl/cpu_sequencer.sv | 120 ++++++++++++
 tb/tb_cpu_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Produces the CPU clock-enable strobe and the 3-bit instruction phase
//   counter. A run/halt/single-step state machine gates execution. Every
//   stop lands on an instruction boundary, after the cycle-7 commit.
//
// Parameters
//   DIV        clk periods per cpuCe pulse while executing (legal 1..65535)
//   START_RUN  1 = leave reset in RUN, 0 = leave reset in HALT
//
// Ports
//   clk        system clock
//   resetN     asynchronous active-low reset
//   runBtn     run/stop toggle button (async level, debounced externally)
//   stepBtn    single-instruction step button (async level, debounced)
//   haltReq    decoder halt request, honoured only at end-of-instruction in RUN
//   cpuCe      one-clk CPU enable strobe
//   cycle      instruction phase 0..7, advances on each cpuCe
//   running    high whenever the state is not HALT
//   instrDone  one-clk pulse after each committed instruction (cycle = 0)
module cpu_sequencer #(
    parameter int unsigned DIV       = 4,
    parameter bit          START_RUN = 1'b0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       runBtn,
    input  logic       stepBtn,
    input  logic       haltReq,
    output logic       cpuCe,
    output logic [2:0] cycle,
    output logic       running,
    output logic       instrDone
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam state_t      RESET_STATE = START_RUN ? RUN : HALT;
    localparam logic [15:0] PRE_MAX     = 16'(DIV - 1);

    state_t      state;
    state_t      nxt;
    logic [15:0] presc;
    logic [1:0]  run_sync;
    logic [1:0]  step_sync;
    logic        run_prev;
    logic        step_prev;
    logic        run_edge;
    logic        step_edge;
    logic        eoi;

    // Edge pulses come straight off the second synchronizer stage, so a
    // press first sampled at edge N acts on the state at edge N+2.
    assign run_edge  = run_sync[1]  & ~run_prev;
    assign step_edge = step_sync[1] & ~step_prev;

    // End of instruction: the cycle-7 strobe is being consumed this edge.
    assign eoi = cpuCe && (cycle == 3'd7);

    always_comb begin
        nxt = state;
        unique case (state)
            HALT: begin
                if (run_edge)       nxt = RUN;   // run wins over step
                else if (step_edge) nxt = STEP;
            end
            RUN: begin
                if (eoi && haltReq) nxt = HALT;
                else if (run_edge)  nxt = DRAIN;
            end
            DRAIN, STEP: begin
                // A run press coinciding with the boundary is swallowed.
                if (eoi)           nxt = HALT;
                else if (run_edge) nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= RESET_STATE;
            running   <= (RESET_STATE != HALT);
            run_sync  <= 2'b00;
            step_sync <= 2'b00;
            run_prev  <= 1'b0;
            step_prev <= 1'b0;
            presc     <= 16'd0;
            cpuCe     <= 1'b0;
            cycle     <= 3'd0;
            instrDone <= 1'b0;
        end else begin
            run_sync  <= {run_sync[0], runBtn};
            step_sync <= {step_sync[0], stepBtn};
            run_prev  <= run_sync[1];
            step_prev <= step_sync[1];

            state   <= nxt;
            running <= (nxt != HALT);

            // Prescaler sits at 0 throughout HALT, including the edge that
            // enters it, so the first strobe after leaving HALT is DIV clks out.
            if (state == HALT || nxt == HALT) presc <= 16'd0;
            else if (presc == PRE_MAX)        presc <= 16'd0;
            else                              presc <= presc + 16'd1;

            // Gating on both current and next state keeps DIV=1 from firing a
            // strobe on the edge that leaves or enters HALT.
            cpuCe <= (state != HALT) && (nxt != HALT) && (presc == PRE_MAX);

            if (cpuCe) cycle <= cycle + 3'd1;

            instrDone <= eoi;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Four instances cover the parameter
// sets needed (DIV=4/halt, DIV=1, DIV=2, DIV=4/start-run); one is observed at
// a time through `sel`. Stimulus pushes expected cpuCe strobes (clk index and
// cycle) and instrDone pulses into queues; a negedge monitor pops and compares.
module tb_cpu_sequencer;

    typedef struct {
        int t;
        int c;
    } ev_t;

    logic clk = 1'b0;
    logic rst_main = 1'b0;
    logic rst_d = 1'b0;
    logic [3:0] run_btn = '0;
    logic [3:0] step_btn = '0;
    logic [3:0] halt_req = '0;
    logic [3:0] ce;
    logic [3:0][2:0] cyc;
    logic [3:0] run;
    logic [3:0] idone;

    int cnt = 0;
    int sel = 0;
    int n_cmp = 0;
    int n_fail = 0;
    ev_t ce_q[$];
    int id_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    cpu_sequencer #(.DIV(4), .START_RUN(1'b0)) u_a (
        .clk(clk), .resetN(rst_main), .runBtn(run_btn[0]), .stepBtn(step_btn[0]),
        .haltReq(halt_req[0]), .cpuCe(ce[0]), .cycle(cyc[0]), .running(run[0]),
        .instrDone(idone[0]));
    cpu_sequencer #(.DIV(1), .START_RUN(1'b0)) u_b (
        .clk(clk), .resetN(rst_main), .runBtn(run_btn[1]), .stepBtn(step_btn[1]),
        .haltReq(halt_req[1]), .cpuCe(ce[1]), .cycle(cyc[1]), .running(run[1]),
        .instrDone(idone[1]));
    cpu_sequencer #(.DIV(2), .START_RUN(1'b0)) u_c (
        .clk(clk), .resetN(rst_main), .runBtn(run_btn[2]), .stepBtn(step_btn[2]),
        .haltReq(halt_req[2]), .cpuCe(ce[2]), .cycle(cyc[2]), .running(run[2]),
        .instrDone(idone[2]));
    cpu_sequencer #(.DIV(4), .START_RUN(1'b1)) u_d (
        .clk(clk), .resetN(rst_d), .runBtn(run_btn[3]), .stepBtn(step_btn[3]),
        .haltReq(halt_req[3]), .cpuCe(ce[3]), .cycle(cyc[3]), .running(run[3]),
        .instrDone(idone[3]));

    // Monitor: every strobe / instrDone on the selected instance must match
    // the head of its expectation queue.
    always @(negedge clk) begin
        if (ce[sel]) begin
            n_cmp++;
            if (ce_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpuCe dut%0d: unexpected strobe at t=%0d cycle=%0d", sel, cnt, cyc[sel]);
            end else begin
                ev_t e;
                e = ce_q.pop_front();
                if (e.t != cnt || e.c != int'(cyc[sel])) begin
                    n_fail++;
                    $display("FAIL cpuCe dut%0d: got t=%0d cycle=%0d, expected t=%0d cycle=%0d",
                             sel, cnt, cyc[sel], e.t, e.c);
                end
            end
        end
        if (idone[sel]) begin
            n_cmp++;
            if (id_q.size() == 0) begin
                n_fail++;
                $display("FAIL instrDone dut%0d: unexpected pulse at t=%0d", sel, cnt);
            end else begin
                int et;
                et = id_q.pop_front();
                if (et != cnt || cyc[sel] != 3'd0) begin
                    n_fail++;
                    $display("FAIL instrDone dut%0d: got t=%0d cycle=%0d, expected t=%0d cycle=0",
                             sel, cnt, cyc[sel], et);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to #1 after the posedge that makes cnt == t.
    task automatic goto(input int t);
        while (cnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // n strobes starting at clk t0, spaced div, phases from c0; each cycle-7
    // strobe is followed one clk later by instrDone.
    task automatic push_run(input int t0, input int div, input int n, input int c0);
        for (int i = 0; i < n; i++) begin
            ev_t e;
            e.t = t0 + i * div;
            e.c = (c0 + i) % 8;
            ce_q.push_back(e);
            if (e.c == 7) id_q.push_back(e.t + 1);
        end
    endtask

    task automatic chk_idle(input string name, input int d);
        chk({name, " running"}, int'(run[d]), 0);
        chk({name, " cycle"}, int'(cyc[d]), 0);
        chk({name, " cpuCe queue left"}, ce_q.size(), 0);
        chk({name, " instrDone queue left"}, id_q.size(), 0);
    endtask

    initial begin
        int k0;
        int k2;
        #200000;
        n_fail++;
        $display("FAIL watchdog: bench did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int k2;
        // Reset state
        goto(2);
        chk("reset cpuCe", int'(ce[0]), 0);
        chk("reset cycle", int'(cyc[0]), 0);
        chk("reset running", int'(run[0]), 0);
        chk("reset instrDone", int'(idone[0]), 0);
        chk("reset running start_run", int'(run[3]), 1);
        chk("reset cpuCe start_run", int'(ce[3]), 0);
        rst_main = 1'b1;

        // Idle in HALT for 100 clks; haltReq in HALT does nothing
        sel = 0;
        halt_req[0] = 1'b1;
        k0 = cnt;
        goto(k0 + 100);
        chk_idle("idle", 0);

        // Single step with haltReq still high: 8 strobes then HALT
        k0 = cnt;
        step_btn[0] = 1'b1;
        push_run(k0 + 7, 4, 8, 0);
        goto(k0 + 2);
        chk("step running before", int'(run[0]), 0);
        goto(k0 + 3);
        chk("step running rise", int'(run[0]), 1);
        goto(k0 + 5);
        step_btn[0] = 1'b0;
        goto(k0 + 40);
        chk_idle("step", 0);
        halt_req[0] = 1'b0;

        // Run then stop at cycle 2: drains to the end of the instruction
        k0 = cnt;
        run_btn[0] = 1'b1;
        push_run(k0 + 7, 4, 8, 0);
        goto(k0 + 4);
        run_btn[0] = 1'b0;
        goto(k0 + 10);
        run_btn[0] = 1'b1;
        goto(k0 + 13);
        chk("drain stop at cycle", int'(cyc[0]), 2);
        goto(k0 + 14);
        run_btn[0] = 1'b0;
        goto(k0 + 30);
        chk("drain still running", int'(run[0]), 1);
        goto(k0 + 40);
        chk_idle("drain", 0);

        // Stop at cycle 2, cancel at cycle 5, later stop again: 16 strobes
        k0 = cnt;
        run_btn[0] = 1'b1;
        push_run(k0 + 7, 4, 16, 0);
        goto(k0 + 4);
        run_btn[0] = 1'b0;
        goto(k0 + 10);
        run_btn[0] = 1'b1;
        goto(k0 + 14);
        run_btn[0] = 1'b0;
        goto(k0 + 21);
        run_btn[0] = 1'b1;
        goto(k0 + 24);
        chk("cancel at cycle", int'(cyc[0]), 5);
        goto(k0 + 25);
        run_btn[0] = 1'b0;
        goto(k0 + 40);
        chk("cancel keeps running", int'(run[0]), 1);
        goto(k0 + 50);
        run_btn[0] = 1'b1;
        goto(k0 + 54);
        run_btn[0] = 1'b0;
        goto(k0 + 72);
        chk_idle("cancel", 0);

        // DIV=1: strobe every clk through four instructions
        sel = 1;
        k0 = cnt;
        run_btn[1] = 1'b1;
        push_run(k0 + 4, 1, 32, 0);
        goto(k0 + 3);
        run_btn[1] = 1'b0;
        goto(k0 + 20);
        chk("div1 running", int'(run[1]), 1);
        goto(k0 + 26);
        run_btn[1] = 1'b1;
        goto(k0 + 29);
        run_btn[1] = 1'b0;
        goto(k0 + 40);
        chk_idle("div1", 1);

        // DIV=2: haltReq raised at cycle 3 halts only after cycle 7
        sel = 2;
        k0 = cnt;
        run_btn[2] = 1'b1;
        push_run(k0 + 5, 2, 8, 0);
        goto(k0 + 4);
        run_btn[2] = 1'b0;
        goto(k0 + 10);
        chk("haltreq raised at cycle", int'(cyc[2]), 3);
        halt_req[2] = 1'b1;
        goto(k0 + 18);
        chk("haltreq not early", int'(run[2]), 1);
        goto(k0 + 24);
        chk_idle("haltreq", 2);
        // haltReq still high: a step runs its full instruction
        goto(k0 + 34);
        k0 = cnt;
        step_btn[2] = 1'b1;
        push_run(k0 + 5, 2, 8, 0);
        goto(k0 + 4);
        step_btn[2] = 1'b0;
        goto(k0 + 24);
        chk_idle("haltreq step", 2);
        halt_req[2] = 1'b0;

        // START_RUN=1: reset mid-instruction aborts immediately
        sel = 3;
        k0 = cnt;
        rst_d = 1'b1;
        push_run(k0 + 4, 4, 6, 0);
        goto(k0 + 24);
        @(negedge clk);
        #1;
        rst_d = 1'b0;
        #1;
        chk("abort cpuCe", int'(ce[3]), 0);
        chk("abort cycle", int'(cyc[3]), 0);
        chk("abort running", int'(run[3]), 1);
        goto(k0 + 27);
        k2 = cnt;
        rst_d = 1'b1;
        push_run(k2 + 4, 4, 4, 0);
        goto(k2 + 18);
        rst_d = 1'b0;
        #1;
        chk("restart cpuCe queue left", ce_q.size(), 0);
        chk("restart instrDone queue left", id_q.size(), 0);
        goto(k2 + 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
